mips_mem_dump: RTL and testbench

MIPS_MEM_DUMP -- requirements
Module: mips_mem_dump

---
 rtl/mips_mem_dump.sv | 109 ++++++++++
 tb/tb_mips_mem_dump.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_dump.sv
// Dumps a window of processor memory to a valid/ready stream while the core is halted.
// Words cost three cycles each (read, capture, present); the halt wait is bounded by HALT_TIMEOUT.
module mips_mem_dump #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int HALT_TIMEOUT = 1000
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              halted,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    localparam int WCNT_W = $clog2(HALT_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WAIT_HALT, READ, CAPTURE, OUT, FIN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cur_addr;
    logic [ADDR_W:0]     remaining;
    logic [WCNT_W-1:0]   wait_cnt;

    always_ff @(posedge clk1) begin
        if (reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cur_addr  <= base_addr;
                    remaining <= count;
                    wait_cnt  <= '0;
                    timeout   <= 1'b0;
                    busy      <= 1'b1;
                    state     <= WAIT_HALT;
                end
                WAIT_HALT: begin
                    if (halted) begin
                        if (remaining != '0) begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= cur_addr;
                            state     <= READ;
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    // the cycle that would make the count HALT_TIMEOUT aborts instead
                    end else if (wait_cnt == WCNT_W'(HALT_TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state   <= FIN;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                READ: state <= CAPTURE;
                CAPTURE: begin
                    out_data  <= mem_rdata;
                    out_addr  <= cur_addr;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    remaining <= remaining - (ADDR_W + 1)'(1);
                    cur_addr  <= cur_addr + ADDR_W'(1);
                    if (remaining == (ADDR_W + 1)'(1)) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= cur_addr + ADDR_W'(1);
                        state     <= READ;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_dump.sv
// Randomized scoreboard bench for mips_mem_dump: expected words are queued at start,
// a negedge monitor pops them on every handshake and checks hold/halt/done rules.
module tb_mips_mem_dump;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk1 = 1'b0;
    logic          reset = 1'b1, start = 1'b0, halted = 1'b0, out_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic          mem_rd_en, out_valid, busy, done, timeout;
    logic [AW-1:0] mem_addr, out_addr;
    logic [DW-1:0] mem_rdata = '0, out_data;

    // second instance with a short halt timeout, halted held low
    logic          start16 = 1'b0, halted16 = 1'b0, ready16 = 1'b1;
    logic [AW-1:0] b16 = '0;
    logic [AW:0]   c16 = 11'd5;
    logic [DW-1:0] rdata16 = '0;
    logic          rd16, ov16, busy16, done16, to16;
    logic [AW-1:0] addr16, oa16;
    logic [DW-1:0] od16;

    always #5 clk1 = ~clk1;

    mips_mem_dump dut (
        .clk1(clk1), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .halted(halted), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .busy(busy), .done(done), .timeout(timeout)
    );

    mips_mem_dump #(.HALT_TIMEOUT(16)) dut16 (
        .clk1(clk1), .reset(reset), .start(start16), .base_addr(b16), .count(c16),
        .halted(halted16), .mem_rd_en(rd16), .mem_addr(addr16), .mem_rdata(rdata16),
        .out_valid(ov16), .out_ready(ready16), .out_data(od16), .out_addr(oa16),
        .busy(busy16), .done(done16), .timeout(to16)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } word_t;

    logic [DW-1:0] mem [0:1023];
    word_t         exp_q[$];
    word_t         w;
    int            checks = 0, passes = 0, cyc = 0, done_cnt = 0, done_target = 0, rd_cnt = 0;
    int            start_cyc = 0, done_cyc = 0, s16_cyc = 0, d16_cyc = 0, last_hs = 0;
    int            rdy_mode = 1, pidx = 0;
    bit            have_last = 0, chk_spacing = 0, halt_seen = 0, prev_hold = 0, bad16 = 0, ok;
    logic [3:0]    pat = 4'b1001;
    logic [DW-1:0] h_data;
    logic [AW-1:0] h_addr;

    // synchronous memory: data valid the cycle after the read strobe
    always @(posedge clk1) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    initial forever begin
        @(posedge clk1);
        #1;
        case (rdy_mode)
            0: out_ready = 1'($urandom_range(0, 1));
            1: out_ready = 1'b1;
            2: begin out_ready = pat[pidx]; pidx = (pidx + 1) % 4; end
            default: out_ready = 1'b0;
        endcase
    end

    // monitor / scoreboard
    initial forever begin
        @(negedge clk1);
        cyc++;
        if (rd16 || ov16 || addr16 != '0 || od16 != '0 || oa16 != '0) bad16 = 1;
        if (start16 && !busy16) s16_cyc = cyc;
        if (done16) d16_cyc = cyc;
        if (reset) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, h_data);
                chk("hold_addr", out_addr, h_addr);
            end
            if (mem_rd_en) begin
                rd_cnt++;
                chk("read_only_after_halted", halt_seen, 1);
            end
            if (out_valid && out_ready) begin
                ok = exp_q.size() != 0;
                chk("word_expected", ok, 1);
                if (ok) begin
                    w = exp_q.pop_front();
                    chk("out_addr", out_addr, w.addr);
                    chk("out_data", out_data, w.data);
                end
                if (chk_spacing && have_last) chk("word_spacing", cyc - last_hs, 3);
                last_hs = cyc;
                have_last = 1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("queue_empty_at_done", exp_q.size(), 0);
            end
            prev_hold = out_valid && !out_ready;
            h_data = out_data;
            h_addr = out_addr;
            if (halted) halt_seen = 1;
            if (start && !busy) begin
                halt_seen = 0;
                start_cyc = cyc;
                have_last = 0;
            end
        end
    end

    task automatic start_dump(input logic [AW-1:0] b, input int c);
        word_t t;
        done_target = done_cnt + 1;
        for (int i = 0; i < c; i++) begin
            t.addr = AW'(int'(b) + i);
            t.data = mem[t.addr];
            exp_q.push_back(t);
        end
        base_addr = b;
        count = (AW + 1)'(c);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt < done_target && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", done_cnt >= done_target, 1);
    endtask

    task automatic do_dump(input logic [AW-1:0] b, input int c, input int pw, input bit drop, input bit spur);
        halted = (pw == 0);
        start_dump(b, c);
        repeat (pw) tick();
        halted = 1'b1;
        repeat (4) tick();
        if (drop) halted = 1'b0;
        if (spur && busy) begin
            base_addr = ~b;
            count = 11'd3;
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_done(20000);
        halted = 1'b1;
        tick();
        chk("rnd_timeout", timeout, 0);
        chk("rnd_idle", busy, 0);
    endtask

    initial begin
        int d0, r0, n;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[198] = 32'd120;
        mem[199] = 32'd0;
        mem[200] = 32'd5;

        repeat (3) tick();
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        reset = 1'b0;
        halted = 1'b1;
        rdy_mode = 1;
        tick();

        // three words at 3-cycle spacing
        chk_spacing = 1;
        start_dump(10'd198, 3);
        wait_done(100);
        chk_spacing = 0;
        tick();
        chk("basic_busy", busy, 0);
        chk("basic_timeout", timeout, 0);
        chk("basic_done_count", done_cnt, 1);

        // late halt: no read until halted rises
        halted = 1'b0;
        r0 = rd_cnt;
        start_dump(10'd200, 1);
        repeat (40) tick();
        chk("no_read_while_running", rd_cnt - r0, 0);
        halted = 1'b1;
        wait_done(100);
        chk("late_halt_timeout", timeout, 0);
        chk("late_halt_reads", rd_cnt - r0, 1);

        // halt timeout on the short-timeout instance
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        repeat (25) tick();
        chk("timeout_done_latency", d16_cyc - s16_cyc, 17);
        chk("timeout_flag", to16, 1);
        chk("timeout_idle", busy16, 0);
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        chk("timeout_cleared_by_start", to16, 0);

        // wrap with back-pressure
        rdy_mode = 2;
        pidx = 0;
        start_dump(10'd1022, 4);
        wait_done(200);
        rdy_mode = 1;

        // zero count plus an ignored second start
        d0 = done_cnt;
        start_dump(10'd5, 0);
        base_addr = 10'd7;
        count = 11'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("zero_count_done_latency", done_cyc - start_cyc, 2);
        chk("zero_count_done_pulses", done_cnt - d0, 1);
        chk("second_start_ignored", busy, 0);

        // reset while presenting a word
        rdy_mode = 3;
        start_dump(10'd10, 5);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("reached_out", out_valid, 1);
        repeat (2) tick();
        d0 = done_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        exp_q.delete();
        repeat (5) tick();
        chk("reset_no_done", done_cnt, d0);
        rdy_mode = 1;
        start_dump(10'd500, 6);
        wait_done(200);

        // random dumps, random back-pressure, halted drops and stray starts
        rdy_mode = 0;
        for (int k = 0; k < 12; k++)
            do_dump(AW'($urandom), $urandom_range(1, 40), $urandom_range(0, 20),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        r0 = rd_cnt;
        do_dump(AW'($urandom), 1024, 0, 1'b1, 1'b1);
        chk("full_dump_reads", rd_cnt - r0, 1024);

        repeat (3) tick();
        chk("timeout_instance_never_read", bad16, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
